// File: rtl/resc_request_scheduler.sv
// resc_request_scheduler
//   Round-robin scheduler that shares one ReSC evaluation wrapper among
//   N_REQ requesters. It grants one pending request, latches that
//   requester's operand, drives the wrapper's start/done handshake and
//   returns the result to the winner as a one-cycle pulse.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   req          per-requester request level
//   x_bin_flat   operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid   one-hot, one-cycle result pulse to the served requester
//   resp_y       result, valid while resp_valid is non-zero
//   resp_err     high with resp_valid when the run was aborted by timeout
//   busy         high in every state except IDLE
//   err_timeout  sticky timeout flag, cleared only by reset
//   res_start    wrapper start (one cycle)
//   res_x_bin    operand presented to the wrapper
//   res_done     wrapper done
//   res_y_bin    wrapper accumulated result
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for any req; arbitrates and latches the operand
// START   | res_start high for one cycle
// CLEAR   | waiting for the wrapper's stale done to drop
// RUN     | waiting for done; captures the result
// DELIVER | resp_valid pulse to the granted requester
module resc_request_scheduler #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 10,
  parameter int TIMEOUT = 1100
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] x_bin_flat,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]       resp_y,
  output logic                   resp_err,
  output logic                   busy,
  output logic                   err_timeout,
  output logic                   res_start,
  output logic [WIDTH-1:0]       res_x_bin,
  input  logic                   res_done,
  input  logic [WIDTH-1:0]       res_y_bin
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  // One-hot encoding so every output decode is a single flop bit.
  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_START   = 5'b00010,
    S_CLEAR   = 5'b00100,
    S_RUN     = 5'b01000,
    S_DELIVER = 5'b10000
  } state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, gnt, pick;
  logic              any_req;
  logic [WIDTH-1:0]  pick_x;
  logic [TW-1:0]     timer;
  logic              timer_tc;
  logic              err_abort;
  logic [N_REQ-1:0]  gnt_oh;
  int                idx;

  // Round-robin scan from ptr; descending offsets so the smallest offset wins.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx[PW-1:0]]) begin
        pick    = idx[PW-1:0];
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    pick_x = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick == PW'(i)) pick_x = x_bin_flat[i*WIDTH +: WIDTH];
  end

  assign timer_tc = (timer == '0);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (any_req) state_nxt = S_START;
      S_START:   state_nxt = S_CLEAR;
      S_CLEAR:   if (timer_tc) state_nxt = S_DELIVER;
                 else if (!res_done) state_nxt = S_RUN;
      S_RUN:     if (res_done || timer_tc) state_nxt = S_DELIVER;
      S_DELIVER: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    for (int i = 0; i < N_REQ; i++) gnt_oh[i] = (gnt == PW'(i));
    res_start  = (state == S_START);
    busy       = (state != S_IDLE);
    resp_valid = (state == S_DELIVER) ? gnt_oh : '0;
    resp_err   = (state == S_DELIVER) && err_abort;
  end

  // Datapath: grant/operand latch, timeout down-counter, result capture.
  // In RUN a done arriving on the terminal-count cycle still wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr         <= '0;
      gnt         <= '0;
      res_x_bin   <= '0;
      resp_y      <= '0;
      err_abort   <= 1'b0;
      err_timeout <= 1'b0;
      timer       <= '0;
    end else begin
      case (state)
        S_IDLE: if (any_req) begin
          gnt       <= pick;
          ptr       <= (pick == PW'(N_REQ - 1)) ? '0 : pick + PW'(1);
          res_x_bin <= pick_x;
          err_abort <= 1'b0;
        end
        S_START: timer <= TW'(TIMEOUT - 1);
        S_CLEAR: begin
          timer <= timer - TW'(1);
          if (timer_tc) begin
            resp_y      <= '0;
            err_abort   <= 1'b1;
            err_timeout <= 1'b1;
          end
        end
        S_RUN: begin
          timer <= timer - TW'(1);
          if (res_done) resp_y <= res_y_bin;
          else if (timer_tc) begin
            resp_y      <= '0;
            err_abort   <= 1'b1;
            err_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_resc_request_scheduler.sv
// Testbench for resc_request_scheduler with a behavioural wrapper stub
// (1024-cycle run, done stays high until the next start).
module tb_resc_request_scheduler;

  localparam int NR = 4;
  localparam int W  = 10;
  localparam int TO = 1100;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] x_bin_flat;
  logic [NR-1:0]   resp_valid;
  logic [W-1:0]    resp_y;
  logic            resp_err;
  logic            busy;
  logic            err_timeout;
  logic            res_start;
  logic [W-1:0]    res_x_bin;
  logic            res_done;
  logic [W-1:0]    res_y_bin;

  resc_request_scheduler #(.N_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .x_bin_flat(x_bin_flat),
    .resp_valid(resp_valid), .resp_y(resp_y), .resp_err(resp_err),
    .busy(busy), .err_timeout(err_timeout), .res_start(res_start),
    .res_x_bin(res_x_bin), .res_done(res_done), .res_y_bin(res_y_bin)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Wrapper stub: start sampled at edge S clears done; done rises at S+1025.
  logic         stub_dead = 1'b0;
  int           stub_cnt;
  logic [W-1:0] stub_x;

  function automatic logic [W-1:0] wrap_fn(input logic [W-1:0] x);
    int v;
    v = (int'(x) * 3 + 7) % 1024;
    return v[W-1:0];
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      res_done  <= 1'b0;
      res_y_bin <= '0;
      stub_cnt  <= 0;
      stub_x    <= '0;
    end else if (res_start) begin
      res_done <= 1'b0;
      stub_cnt <= 1025;
      stub_x   <= res_x_bin;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && !stub_dead) begin
        res_done  <= 1'b1;
        res_y_bin <= wrap_fn(stub_x);
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state
  logic [NR-1:0] req_v;
  logic [W-1:0]  opnd [NR];
  int            model_ptr;
  bit            sticky_exp;

  function automatic int rr_pick(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++)
      if (r[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  task automatic apply();
    req = req_v;
    for (int i = 0; i < NR; i++) x_bin_flat[i*W +: W] = opnd[i];
  endtask

  // One complete transaction. Drops the served req at the pulse.
  task automatic serve(input bit expect_to, input bit change_opnd, output int served);
    int           exp_idx, t0;
    logic [W-1:0] exp_x;
    bit           seen;
    exp_idx = rr_pick(req_v, model_ptr);
    served  = exp_idx;
    if (exp_idx < 0) begin
      chk_eq("model_has_req", 0, 1);
      return;
    end
    exp_x = opnd[exp_idx];
    seen  = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (res_start) seen = 1;
    end
    chk_eq("grant_seen", 32'(seen), 1);
    if (!seen) return;
    t0 = cyc;
    chk_eq("res_x_bin", res_x_bin, exp_x);
    chk_eq("busy_run", busy, 1);
    model_ptr = (exp_idx + 1) % NR;
    @(negedge clk);
    chk_eq("start_one_cycle", res_start, 0);
    if (change_opnd) begin
      repeat (8) @(negedge clk);
      opnd[exp_idx] = ~exp_x;
      apply();
    end
    seen = 0;
    for (int n = 0; n < 1200 && !seen; n++) begin
      @(negedge clk);
      if (resp_valid != '0) seen = 1;
    end
    chk_eq("resp_seen", 32'(seen), 1);
    if (!seen) return;
    chk_eq("latency", cyc - t0, expect_to ? TO + 1 : 1027);
    chk_eq("resp_valid", resp_valid, 1 << exp_idx);
    chk_eq("resp_y", resp_y, expect_to ? 0 : wrap_fn(exp_x));
    chk_eq("resp_err", resp_err, expect_to);
    chk_eq("err_timeout", err_timeout, sticky_exp);
    chk_eq("res_x_hold", res_x_bin, exp_x);
    req_v[exp_idx] = 1'b0;
    apply();
    @(negedge clk);
    chk_eq("valid_one_cycle", resp_valid, 0);
    chk_eq("busy_idle", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk_eq({tag, "_valid"}, resp_valid, 0);
    chk_eq({tag, "_y"}, resp_y, 0);
    chk_eq({tag, "_err"}, resp_err, 0);
    chk_eq({tag, "_busy"}, busy, 0);
    chk_eq({tag, "_sticky"}, err_timeout, 0);
    chk_eq({tag, "_start"}, res_start, 0);
    chk_eq({tag, "_xbin"}, res_x_bin, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  served;
    bit  seen;
    reset      = 1'b0;
    req_v      = '0;
    model_ptr  = 0;
    sticky_exp = 0;
    for (int i = 0; i < NR; i++) opnd[i] = W'($urandom_range(0, 1023));
    opnd[0] = 10'd512;
    apply();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // Contention: all four held, re-raised after each response.
    req_v = '1;
    apply();
    for (int t = 0; t < 5; t++) begin
      serve(0, 0, served);
      chk_eq("rr_order", served, t % NR);
      if (served >= 0) begin
        req_v[served] = 1'b1;
        opnd[served]  = W'($urandom_range(0, 1023));
        apply();
      end
    end

    // Random request patterns and operand changes after grant.
    for (int t = 0; t < 10; t++) begin
      serve(0, (t == 0) || ($urandom_range(0, 3) == 0), served);
      for (int i = 0; i < NR; i++)
        if (!req_v[i] && $urandom_range(0, 2) == 0) begin
          req_v[i] = 1'b1;
          opnd[i]  = W'($urandom_range(0, 1023));
        end
      if (req_v == '0) begin
        served        = int'($urandom_range(0, NR - 1));
        req_v[served] = 1'b1;
        opnd[served]  = W'($urandom_range(0, 1023));
      end
      apply();
    end

    // Timeout: wrapper never reports done.
    stub_dead  = 1'b1;
    sticky_exp = 1;
    serve(1, 0, served);
    stub_dead = 1'b0;
    if (req_v == '0) begin
      req_v[1] = 1'b1;
      opnd[1]  = W'($urandom_range(0, 1023));
      apply();
    end
    serve(0, 0, served);
    chk_eq("sticky_hold", err_timeout, 1);

    // Reset mid-run, then round-robin restarts from pointer 0.
    req_v = '0;
    apply();
    repeat (3) @(negedge clk);
    req_v    = 4'b0100;
    opnd[2]  = W'($urandom_range(1, 1023));
    apply();
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (res_start) seen = 1;
    end
    chk_eq("pre_reset_grant", res_x_bin, opnd[2]);
    repeat (499) @(negedge clk);
    reset = 1'b0;
    req_v = 4'b1010;
    opnd[1] = W'($urandom_range(0, 1023));
    opnd[3] = W'($urandom_range(0, 1023));
    apply();
    @(negedge clk);
    check_all_zero("midrun_reset");
    reset      = 1'b1;
    model_ptr  = 0;
    sticky_exp = 0;
    serve(0, 0, served);
    chk_eq("post_reset_winner", served, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
